// File: rtl/output_checker.sv
// Output stream scoreboard: compares DUT bytes against golden memory
// and reports mismatch count, first mismatch, max deviation and pass.
module output_checker #(
  parameter int NUM_OUTPUTS = 80,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int TOL         = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              dut_valid,
  input  logic [DATA_W-1:0] dut_data,
  output logic              dut_ready,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W:0]   max_abs_diff,
  output logic              overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_OUTPUTS - 1);
  localparam logic [DATA_W:0]   TOL_V = (DATA_W+1)'(TOL);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       err_q, err_d;
  logic              found_q, found_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [DATA_W-1:0] fg_q, fg_d;
  logic [DATA_W-1:0] fe_q, fe_d;
  logic [DATA_W:0]   max_q, max_d;
  logic              ovr_q, ovr_d;

  logic [DATA_W:0]   diff;
  logic [DATA_W:0]   absd;
  logic              miss;

  // Sign-extend both bytes so the difference never overflows.
  assign diff = {dut_data[DATA_W-1], dut_data}
              - {exp_data[DATA_W-1], exp_data};
  assign absd = diff[DATA_W] ? -diff : diff;
  assign miss = absd > TOL_V;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    found_d = found_q;
    fa_d    = fa_q;
    fg_d    = fg_q;
    fe_d    = fe_q;
    max_d   = max_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_RUN: begin
        if (dut_valid) begin
          if (miss) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (!found_q) begin
              found_d = 1'b1;
              fa_d    = addr_q;
              fg_d    = dut_data;
              fe_d    = exp_data;
            end
          end
          if (absd > max_q) max_d = absd;
          if (addr_q == LAST) state_d = S_DONE;
          else addr_d = addr_q + 1'b1;
        end
      end
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = '0;
          err_d   = '0;
          found_d = 1'b0;
          fa_d    = '0;
          fg_d    = '0;
          fe_d    = '0;
          max_d   = '0;
          ovr_d   = 1'b0;
        end else if (state_q == S_DONE && dut_valid) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      err_q   <= '0;
      found_q <= 1'b0;
      fa_q    <= '0;
      fg_q    <= '0;
      fe_q    <= '0;
      max_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      found_q <= found_d;
      fa_q    <= fa_d;
      fg_q    <= fg_d;
      fe_q    <= fe_d;
      max_q   <= max_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy           = state_q == S_RUN;
  assign dut_ready      = state_q == S_RUN;
  assign done           = state_q == S_DONE;
  assign pass           = done && err_q == 16'd0 && !ovr_q;
  assign exp_addr       = addr_q;
  assign err_count      = err_q;
  assign first_err_addr = fa_q;
  assign first_err_got  = fg_q;
  assign first_err_exp  = fe_q;
  assign max_abs_diff   = max_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_output_checker.sv
// Bench for output_checker: two instances (TOL=0, TOL=2) on one stream,
// checked every cycle against a behavioural scoreboard model.
module tb_output_checker;

  localparam int N = 80;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       dut_valid = 1'b0;
  logic [7:0] dut_data = 8'h00;

  logic [7:0] gold [N];

  logic        rdy  [2];
  logic [15:0] ea   [2];
  logic [7:0]  ed   [2];
  logic        bsy  [2];
  logic        dn   [2];
  logic        ps   [2];
  logic [15:0] ec   [2];
  logic [15:0] fa   [2];
  logic [7:0]  fg   [2];
  logic [7:0]  fe   [2];
  logic [8:0]  mx   [2];
  logic        ov   [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ed[0] = (ea[0] < 16'(N)) ? gold[ea[0]] : 8'h00;
  assign ed[1] = (ea[1] < 16'(N)) ? gold[ea[1]] : 8'h00;

  output_checker #(.NUM_OUTPUTS(N), .ADDR_W(16), .DATA_W(8), .TOL(0)) u0 (
    .clk(clk), .rstn(rstn), .start(start),
    .dut_valid(dut_valid), .dut_data(dut_data), .dut_ready(rdy[0]),
    .exp_addr(ea[0]), .exp_data(ed[0]), .busy(bsy[0]), .done(dn[0]),
    .pass(ps[0]), .err_count(ec[0]), .first_err_addr(fa[0]),
    .first_err_got(fg[0]), .first_err_exp(fe[0]),
    .max_abs_diff(mx[0]), .overrun(ov[0])
  );

  output_checker #(.NUM_OUTPUTS(N), .ADDR_W(16), .DATA_W(8), .TOL(2)) u1 (
    .clk(clk), .rstn(rstn), .start(start),
    .dut_valid(dut_valid), .dut_data(dut_data), .dut_ready(rdy[1]),
    .exp_addr(ea[1]), .exp_data(ed[1]), .busy(bsy[1]), .done(dn[1]),
    .pass(ps[1]), .err_count(ec[1]), .first_err_addr(fa[1]),
    .first_err_got(fg[1]), .first_err_exp(fe[1]),
    .max_abs_diff(mx[1]), .overrun(ov[1])
  );

  // Scoreboard model: 0=idle, 1=run, 2=done
  int tol [2] = '{0, 2};
  int ms  [2] = '{0, 0};
  int ma  [2] = '{0, 0};
  int me  [2] = '{0, 0};
  int mf  [2] = '{0, 0};
  int mfa [2] = '{0, 0};
  int mfg [2] = '{0, 0};
  int mfe [2] = '{0, 0};
  int mm  [2] = '{0, 0};
  int mo  [2] = '{0, 0};

  task automatic mclear(input int k);
    ma[k] = 0; me[k] = 0; mf[k] = 0; mfa[k] = 0;
    mfg[k] = 0; mfe[k] = 0; mm[k] = 0; mo[k] = 0;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        ms[k] = 0;
        mclear(k);
      end else if (ms[k] == 1) begin
        if (dut_valid) begin
          int d;
          int a;
          d = int'($signed(dut_data)) - int'($signed(gold[ma[k]]));
          a = (d < 0) ? -d : d;
          if (a > tol[k]) begin
            if (me[k] < 65535) me[k] = me[k] + 1;
            if (mf[k] == 0) begin
              mf[k] = 1; mfa[k] = ma[k];
              mfg[k] = int'(dut_data); mfe[k] = int'(gold[ma[k]]);
            end
          end
          if (a > mm[k]) mm[k] = a;
          if (ma[k] == N - 1) ms[k] = 2;
          else ma[k] = ma[k] + 1;
        end
      end else if (start) begin
        ms[k] = 1;
        mclear(k);
      end else if (ms[k] == 2 && dut_valid) begin
        mo[k] = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m%0d.busy", k), 32'(bsy[k]), 32'(ms[k] == 1));
      chk($sformatf("m%0d.ready", k), 32'(rdy[k]), 32'(ms[k] == 1));
      chk($sformatf("m%0d.done", k), 32'(dn[k]), 32'(ms[k] == 2));
      chk($sformatf("m%0d.pass", k), 32'(ps[k]),
          32'(ms[k] == 2 && me[k] == 0 && mo[k] == 0));
      chk($sformatf("m%0d.addr", k), 32'(ea[k]), 32'(ma[k]));
      chk($sformatf("m%0d.err", k), 32'(ec[k]), 32'(me[k]));
      chk($sformatf("m%0d.fa", k), 32'(fa[k]), 32'(mfa[k]));
      chk($sformatf("m%0d.fg", k), 32'(fg[k]), 32'(mfg[k]));
      chk($sformatf("m%0d.fe", k), 32'(fe[k]), 32'(mfe[k]));
      chk($sformatf("m%0d.max", k), 32'(mx[k]), 32'(mm[k]));
      chk($sformatf("m%0d.ovr", k), 32'(ov[k]), 32'(mo[k]));
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Streams golden bytes with optional gap percentage, one corrupted index
  // and an optional one-cycle reset at a given transfer count.
  task automatic stream(input int gap, input int bad_idx,
                        input logic [7:0] bad_val, input int rst_at);
    int idx = 0;
    int cyc = 0;
    while (idx < N && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (idx == rst_at) begin
        rstn = 1'b0;
        dut_valid = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        dut_valid = 1'b0;
        return;
      end
      dut_valid = ($urandom_range(99) >= 32'(gap));
      dut_data = (idx == bad_idx) ? bad_val : gold[idx];
      if (dut_valid && rdy[0]) idx++;
    end
    @(negedge clk);
    dut_valid = 1'b0;
    chk("stream_timeout", 32'(idx), 32'(N));
  endtask

  initial begin
    for (int i = 0; i < N; i++) gold[i] = 8'(i * 37 + 5);
    for (int i = 0; i < 8; i++) gold[i] = 8'h95;
    gold[8]  = 8'haa;
    gold[9]  = 8'h6d;
    gold[10] = 8'h80;
    gold[11] = 8'h7f;

    repeat (3) @(negedge clk);
    chk("rst.addr", 32'(ea[0]), 32'h0);
    chk("rst.done", 32'(dn[0]), 32'h0);
    chk("rst.ready", 32'(rdy[0]), 32'h0);
    rstn = 1'b1;

    // Valid in IDLE is ignored.
    @(negedge clk); dut_valid = 1'b1;
    @(negedge clk); dut_valid = 1'b0;
    chk("idle.ovr", 32'(ov[0]), 32'h0);

    pulse_start();
    stream(0, -1, 8'h00, -1);
    chk("clean.done", 32'(dn[0]), 32'h1);
    chk("clean.pass", 32'(ps[0]), 32'h1);
    chk("clean.err", 32'(ec[0]), 32'h0);
    chk("clean.max", 32'(mx[0]), 32'h0);
    chk("clean.addr", 32'(ea[0]), 32'h4f);

    pulse_start();
    stream(0, 9, 8'h95, -1);
    chk("b9.err", 32'(ec[0]), 32'h1);
    chk("b9.fa", 32'(fa[0]), 32'h9);
    chk("b9.fg", 32'(fg[0]), 32'h95);
    chk("b9.fe", 32'(fe[0]), 32'h6d);
    chk("b9.max", 32'(mx[0]), 32'd216);
    chk("b9.pass", 32'(ps[0]), 32'h0);

    pulse_start();
    stream(0, 0, 8'h97, -1);
    chk("tol2.err", 32'(ec[1]), 32'h0);
    chk("tol2.max", 32'(mx[1]), 32'd2);
    chk("tol2.pass", 32'(ps[1]), 32'h1);
    chk("tol0.err", 32'(ec[0]), 32'h1);
    chk("tol0.fa", 32'(fa[0]), 32'h0);

    pulse_start();
    stream(0, 0, 8'h98, -1);
    chk("tol3.err", 32'(ec[1]), 32'h1);
    chk("tol3.max", 32'(mx[1]), 32'd3);

    pulse_start();
    stream(50, -1, 8'h00, -1);
    chk("gap.pass", 32'(ps[0]), 32'h1);
    chk("gap.addr", 32'(ea[0]), 32'h4f);

    @(negedge clk); dut_valid = 1'b1;
    @(negedge clk); dut_valid = 1'b0;
    chk("ovr.flag", 32'(ov[0]), 32'h1);
    chk("ovr.pass", 32'(ps[0]), 32'h0);
    chk("ovr.done", 32'(dn[0]), 32'h1);

    pulse_start();
    chk("restart.busy", 32'(bsy[0]), 32'h1);
    chk("restart.ovr", 32'(ov[0]), 32'h0);
    chk("restart.done", 32'(dn[0]), 32'h0);

    stream(0, -1, 8'h00, 40);
    chk("midrst.busy", 32'(bsy[0]), 32'h0);
    chk("midrst.addr", 32'(ea[0]), 32'h0);
    chk("midrst.ready", 32'(rdy[0]), 32'h0);

    pulse_start();
    chk("again.addr", 32'(ea[0]), 32'h0);
    chk("again.busy", 32'(bsy[0]), 32'h1);
    stream(20, 79, 8'h00, -1);
    chk("last.fa", 32'(fa[0]), 32'h4f);
    chk("last.err", 32'(ec[0]), 32'h1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_checker.md
Name: output_checker

Overview:
- Testbench-side scoreboard that sits directly downstream of the LSTM accelerator's output stream and alongside the golden output memory.
- Accepts DUT output bytes over a valid/ready handshake and drives the read address into the golden memory, which has a combinational read.
- Compares each received byte against the expected byte, with an optional tolerance.
- Reports error count, first-mismatch details, maximum deviation and a final pass/fail.

Parameters:
- NUM_OUTPUTS, 80, number of output bytes expected per run (golden addresses 0..NUM_OUTPUTS-1).
- ADDR_W, 16, golden memory address width.
- DATA_W, 8, output byte width; values are two's-complement signed.
- TOL, 0, maximum allowed absolute difference (in LSBs) that still counts as a match.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a checking run.
- dut_valid  in  1  DUT output byte is valid.
- dut_data  in  DATA_W  DUT output byte.
- dut_ready  out  1  checker accepts a byte this cycle.
- exp_addr  out  ADDR_W  read address into the golden memory.
- exp_data  in  DATA_W  golden byte at exp_addr, valid in the same cycle.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start or reset.
- pass  out  1  valid while done=1; high iff err_count==0 and overrun==0.
- err_count  out  16  number of mismatches; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  index of the first mismatch.
- first_err_got  out  DATA_W  DUT byte at the first mismatch.
- first_err_exp  out  DATA_W  golden byte at the first mismatch.
- max_abs_diff  out  9  largest |dut-exp| seen this run (signed difference, 0..255).
- overrun  out  1  sticky flag: dut_valid was seen while in DONE.

Behaviour:
- Reset (rstn=0 at a clock edge, any state): the following outputs go to 0: state=IDLE, exp_addr, busy, done, pass, dut_ready, err_count, first_err_*, max_abs_diff, overrun.
- States: IDLE, RUN, DONE.
- IDLE:
  - dut_ready=0.
  - start=1 -> RUN next cycle; clears exp_addr, err_count, first_err_*, max_abs_diff and overrun.
- RUN:
  - busy=1, dut_ready=1 combinationally.
  - A transfer occurs when dut_valid & dut_ready.
  - On a transfer: diff = sext(dut_data) - sext(exp_data), computed in 9 bits; absd = |diff|.
    - Mismatch iff absd > TOL.
    - Mismatch -> err_count+1 (saturating).
    - If this is the first mismatch, capture first_err_addr = exp_addr, first_err_got = dut_data, first_err_exp = exp_data.
    - max_abs_diff = max(max_abs_diff, absd).
    - exp_addr increments.
  - Transfer when exp_addr == NUM_OUTPUTS-1 -> DONE next cycle. exp_addr does not wrap; it holds NUM_OUTPUTS-1.
  - start asserted in RUN is ignored.
  - Cycles with no dut_valid: no state change, exp_addr holds.
- Latency: compare result is registered; counters and flags reflect a transfer one cycle after it.
- DONE:
  - done=1, busy=0, dut_ready=0.
  - pass = (err_count==0) & ~overrun.
  - dut_valid=1 in DONE sets overrun, which clears pass. The byte is not compared.
  - start=1 -> clear as in IDLE and enter RUN; done drops the next cycle.
- dut_valid in IDLE is ignored and does not set overrun.
- "First mismatch" tracking uses an internal flag cleared on start, so address 0 is a valid first_err_addr.
- NUM_OUTPUTS=1: a single transfer goes RUN->DONE.

Test Plan:
- Golden memory loaded with 8'h95 at addr 0..7 and 8'haa at addr 8. Stream 80 bytes equal to the golden contents, with dut_valid continuously high -> DONE after 80 transfers, done=1, pass=1, err_count=0, max_abs_diff=0, exp_addr held at 16'h4f.
- Same stream but byte 9 sent as 8'h95 instead of 8'h6d -> err_count=1, first_err_addr=16'h9, first_err_got=8'h95, first_err_exp=8'h6d, max_abs_diff=216, pass=0.
- TOL=2. Byte 0 sent as 8'h97 (expected 8'h95) -> match, max_abs_diff=2. Byte 0 sent as 8'h98 -> mismatch, err_count=1.
- Random dut_valid gaps (about 50% duty) with a correct stream -> exp_addr advances only on transfers; pass=1 after exactly 80 transfers.
- After DONE, assert dut_valid for one cycle -> overrun=1, pass=0. Then pulse start -> all flags cleared, busy=1.
- rstn low for one cycle at transfer 40 -> all outputs 0 and IDLE next cycle. Then start -> exp_addr restarts at 0.
